// File: rtl/wbl_write_seq.sv
// Latches a key, walks rows through the WBL generator and streams 16 captured words per row to the array.
// Row cost is SETTLE_CYC+1+16 cycles at full ready; words hold steady while wr_ready is low.
module wbl_write_seq #(
   parameter int SETTLE_CYC = 2,
   parameter int NUM_COLS   = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          key_only,
   input  logic          abort,
   input  logic [127:0]  key_in,
   output logic [127:0]  gen_kin,
   output logic [5:0]    gen_addr,
   input  logic [1023:0] gen_wbl,
   output logic          wr_valid,
   input  logic          wr_ready,
   output logic [5:0]    wr_row,
   output logic [3:0]    wr_col,
   output logic [63:0]   wr_data,
   output logic          busy,
   output logic          done,
   output logic          aborted
);

   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_ISSUE} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [CW-1:0]  r_cnt;
   logic           r_mode;
   logic           r_done;
   logic           r_aborted;
   logic [1023:0]  r_buf;

   logic           w_issue;
   logic           w_accept;
   logic           w_last_col;
   logic           w_last_row;
   logic [5:0]     w_next_row;

   assign w_issue    = (r_state == S_ISSUE);
   assign w_accept   = w_issue && wr_ready;
   assign w_last_col = (wr_col == 4'(NUM_COLS - 1));
   assign w_last_row = r_mode ? (gen_addr == 6'd34) : (gen_addr == 6'd63);
   // key-bearing rows jump from the low bank (0..2) to the high bank (32..34)
   assign w_next_row = (r_mode && gen_addr == 6'd2) ? 6'd32 : gen_addr + 6'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start && !abort) w_next = S_SETTLE;
         S_SETTLE:  if (abort) w_next = S_IDLE;
                    else if (r_cnt == '0) w_next = S_CAPTURE;
         S_CAPTURE: w_next = abort ? S_IDLE : S_ISSUE;
         S_ISSUE:   if (abort) w_next = S_IDLE;
                    else if (w_accept && w_last_col) w_next = w_last_row ? S_IDLE : S_SETTLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      wr_valid = w_issue;
      busy     = (r_state != S_IDLE);
      wr_data  = w_issue ? r_buf[{wr_col, 6'b0} +: 64] : 64'd0;
      done     = r_done;
      aborted  = r_aborted;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gen_kin   <= '0;
         gen_addr  <= '0;
         wr_row    <= '0;
         wr_col    <= '0;
         r_cnt     <= '0;
         r_mode    <= 1'b0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_aborted <= abort && (r_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (start && !abort) begin
                  gen_kin  <= key_in;
                  r_mode   <= key_only;
                  gen_addr <= 6'd0;
                  r_cnt    <= CW'(SETTLE_CYC - 1);
               end
            end
            S_SETTLE: begin
               if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            end
            S_CAPTURE: begin
               wr_col <= 4'd0;
               wr_row <= gen_addr;
            end
            S_ISSUE: begin
               // a word taken alongside abort still advances the column
               if (w_accept) begin
                  wr_col <= wr_col + 4'd1;
                  if (w_last_col && !abort) begin
                     if (w_last_row) begin
                        r_done <= 1'b1;
                     end else begin
                        gen_addr <= w_next_row;
                        r_cnt    <= CW'(SETTLE_CYC - 1);
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_CAPTURE) r_buf <= gen_wbl;
   end

endmodule

// File: doc/wbl_write_seq.md
Name: wbl_write_seq

Overview:
- Sequencer directly downstream of the combinational WBL key generator.
- Latches a 128-bit AES key and drives it, plus a 6-bit row address, to the generator.
- After a programmable settle time, captures the sixteen 64-bit WBL words for that row and streams them, one per accepted transfer, into the DRAM-CIM array write port over a valid/ready handshake.
- Walks either all 64 rows or only the six key-bearing rows.

Parameters:
SETTLE_CYC, 2, cycles gen_addr/gen_kin are held before capture (≥1; covers generator combinational depth)
NUM_COLS, 16, WBL words per row (fixed 16; parameter exists only for bench visibility)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a load sequence; sampled only in IDLE
key_only  in  1  sampled with start: 1 = rows {0,1,2,32,33,34}, 0 = rows 0..63
abort  in  1  terminate the active sequence
key_in  in  128  AES key; latched on accepted start
gen_kin  out  128  key to generator; equals the latched key
gen_addr  out  6  row address to generator
gen_wbl  in  1024  generator outputs; WBLn occupies bits [64n-1 : 64(n-1)]
wr_valid  out  1  write-word valid
wr_ready  in  1  array accepts the word
wr_row  out  6  row of the current word
wr_col  out  4  column index; 0 = WBL1 … 15 = WBL16
wr_data  out  64  word data
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last word is accepted
aborted  out  1  one-cycle pulse when abort terminates a sequence

Behaviour:
- Reset (async assert, synchronous-release flops): state=IDLE; gen_kin=0; gen_addr=0; wr_valid=0; wr_row=0; wr_col=0; wr_data=0; busy=0; done=0; aborted=0.
- FSM states: IDLE, SETTLE, CAPTURE, ISSUE.
- IDLE:
  - On start=1 && abort=0: latch key_in to gen_kin and key_only to the mode register; set gen_addr to the first row (0); load settle counter with SETTLE_CYC-1; go to SETTLE.
  - start while busy is ignored.
- SETTLE: hold gen_addr/gen_kin; count down; at 0 go to CAPTURE. Total time in SETTLE is exactly SETTLE_CYC cycles.
- CAPTURE (1 cycle): register all 1024 bits of gen_wbl into a local buffer; set wr_col=0, wr_row=gen_addr; go to ISSUE.
- ISSUE:
  - wr_valid=1; wr_data = buffer word[wr_col].
  - On wr_valid && wr_ready, advance wr_col. wr_data/wr_row/wr_col stay stable while wr_ready=0.
  - When word 15 is accepted:
    - If this is the last row: go to IDLE, pulse done next cycle, drop wr_valid.
    - Otherwise: gen_addr = next row, go to SETTLE (wr_valid=0).
- Row sequence:
  - key_only=1: 0→1→2→32→33→34 (last row 34).
  - key_only=0: 0→63 by +1 (last row 63; no wrap).
- Mode and key are frozen for the whole sequence; changes on key_in/key_only while busy have no effect.
- abort:
  - In any non-IDLE state: next state IDLE, wr_valid deasserts the next cycle, aborted pulses, done does not pulse.
  - Dropping wr_valid without acceptance is permitted only on abort.
  - A word accepted in the same cycle as abort still counts as written.
  - Abort in IDLE is ignored. start and abort together in IDLE: abort wins, no sequence starts.
- Cycles per row = SETTLE_CYC + 1 + 16 (with wr_ready=1).
- Reset mid-sequence behaves as abort without the aborted pulse.

Test Plan:
1. Stub generator (each WBLn word = {58'b0, gen_addr} ^ (n<<56)), SETTLE_CYC=2, key_only=1, wr_ready=1, start at cycle 0 → 96 writes on rows 0,1,2,32,33,34; wr_col 0..15 per row; data matches stub; last accept at cycle 114; done pulse at cycle 115; busy low at 115.
2. Same, key_only=0 → 1024 writes, rows 0..63 in order, done at cycle 1217, no row beyond 63.
3. Real generator, key 2b7e151628aed2a6abf7158809cf4f3c, key_only=1 → wr_data matches the bench AES key-schedule model for all 96 words; gen_kin stable throughout.
4. wr_ready randomly low 50% → wr_data/wr_row/wr_col hold while stalled; word order and count unchanged.
5. abort asserted during the 5th word of row 32 → wr_valid low the next cycle; aborted pulses once; no done; a new start afterwards restarts at row 0 with the new key.
6. start held high while busy, plus start+abort together in IDLE → no restart and no sequence respectively; rst_n low mid-ISSUE → all outputs at reset values immediately.
